uart_echo_buffered: RTL and testbench

Parametrised echo engine placed between the receive and transmit sides of the `uart` core. Each received byte is pushed into an internal FIFO, optionally upper-cased, and replayed to the transmitter under the `tx_req`/`tx_busy` handshake. In line mode, echo is held back until a full line has been received. A sticky overflow flag and a live fill level are exported for debug LEDs.

---
 rtl/uart_echo_buffered.sv | 163 ++++++++++++++++
 tb/tb_uart_echo_buffered.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_echo_buffered.sv
// Echo engine between uart receive and transmit sides.
// Buffers received bytes in a FIFO and replays them over the tx_req/tx_busy handshake.
//
// Ports:
//   clk       : rising-edge clock
//   reset_n   : asynchronous active-low reset
//   rx_ready  : one-cycle pulse, rx_byte valid
//   rx_byte   : received byte
//   tx_busy   : transmitter busy (rises the cycle after tx_req)
//   tx_req    : one-cycle send request
//   tx_byte   : registered byte to send, stable until next tx_req
//   level     : FIFO occupancy 0..2^DEPTH_LOG2
//   full      : level == 2^DEPTH_LOG2
//   empty     : level == 0
//   overflow  : sticky, a received byte was dropped
module uart_echo_buffered #(
    parameter int                DATA_W     = 8,
    parameter int                DEPTH_LOG2 = 4,
    parameter int                LINE_MODE  = 0,
    parameter logic [DATA_W-1:0] EOL        = DATA_W'(8'h0D),
    parameter int                UPPERCASE  = 0
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  rx_ready,
    input  logic [DATA_W-1:0]     rx_byte,
    input  logic                  tx_busy,
    output logic                  tx_req,
    output logic [DATA_W-1:0]     tx_byte,
    output logic [DEPTH_LOG2:0]   level,
    output logic                  full,
    output logic                  empty,
    output logic                  overflow
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] L_DEPTH = {1'b1, {DEPTH_LOG2{1'b0}}};
    localparam bit CASE_EN = (DATA_W == 8) && (UPPERCASE != 0);
    localparam logic [DATA_W-1:0] LC_A     = DATA_W'(8'h61);
    localparam logic [DATA_W-1:0] LC_Z     = DATA_W'(8'h7A);
    localparam logic [DATA_W-1:0] CASE_OFS = DATA_W'(8'h20);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SEND = 2'd1;
    localparam logic [1:0] S_HOLD = 2'd2;

    logic [DATA_W-1:0]     r_mem [DEPTH];
    logic [DEPTH_LOG2-1:0] r_wr_ptr;
    logic [DEPTH_LOG2-1:0] r_rd_ptr;
    logic [DEPTH_LOG2:0]   r_level;
    logic [DEPTH_LOG2:0]   r_lines;
    logic                  r_force;
    logic                  r_ovf;
    logic [1:0]            r_state;
    logic                  r_tx_req;
    logic [DATA_W-1:0]     r_tx_byte;

    logic                  w_full;
    logic                  w_empty;
    logic                  w_drain;
    logic                  w_pop;
    logic                  w_push;
    logic [DATA_W-1:0]     w_head;
    logic [DATA_W-1:0]     w_wr_data;
    logic                  w_line_inc;
    logic                  w_line_dec;

    assign w_full  = (r_level == L_DEPTH);
    assign w_empty = (r_level == '0);
    assign w_head  = r_mem[r_rd_ptr];

    // In line mode a stale force flag can survive one cycle past empty,
    // so drain is always gated by a non-empty FIFO.
    assign w_drain = !w_empty &&
                     ((LINE_MODE == 0) || (r_lines != '0) || r_force);

    assign w_pop  = (r_state == S_IDLE) && w_drain;
    assign w_push = rx_ready && (!w_full || w_pop);

    // EOL matching is on the raw byte; upper-casing never alters EOL.
    assign w_line_inc = w_push && (rx_byte == EOL);
    assign w_line_dec = w_pop && (w_head == EOL);

    always_comb begin
        w_wr_data = rx_byte;
        if (CASE_EN && rx_byte >= LC_A && rx_byte <= LC_Z)
            w_wr_data = rx_byte - CASE_OFS;
    end

    always_ff @(posedge clk) begin
        if (w_push)
            r_mem[r_wr_ptr] <= w_wr_data;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
            r_lines  <= '0;
            r_force  <= 1'b0;
            r_ovf    <= 1'b0;
        end else begin
            if (w_push)
                r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + 1'b1;

            if (w_push && !w_pop)
                r_level <= r_level + 1'b1;
            else if (w_pop && !w_push)
                r_level <= r_level - 1'b1;

            if (w_line_inc && !w_line_dec)
                r_lines <= r_lines + 1'b1;
            else if (w_line_dec && !w_line_inc)
                r_lines <= r_lines - 1'b1;

            // Lets an over-long line drain instead of deadlocking.
            if (w_full)
                r_force <= 1'b1;
            else if (w_empty)
                r_force <= 1'b0;

            if (rx_ready && !w_push)
                r_ovf <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= S_IDLE;
            r_tx_req  <= 1'b0;
            r_tx_byte <= '0;
        end else begin
            r_tx_req <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_drain) begin
                        r_tx_req  <= 1'b1;
                        r_tx_byte <= w_head;
                        r_state   <= S_SEND;
                    end
                end
                // tx_busy is still rising here, so it is not looked at.
                S_SEND: r_state <= S_HOLD;
                S_HOLD: begin
                    if (!tx_busy)
                        r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign tx_req   = r_tx_req;
    assign tx_byte  = r_tx_byte;
    assign level    = r_level;
    assign full     = w_full;
    assign empty    = w_empty;
    assign overflow = r_ovf;

endmodule

// File: tb/tb_uart_echo_buffered.sv
// Bench for uart_echo_buffered: byte mode with upper-casing (depth 16)
// and line mode (depth 4), each against a queue-based expectation.
module tb_uart_echo_buffered;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Instance A: byte mode, UPPERCASE=1, depth 16
    logic       a_rst_n = 1'b0;
    logic       a_rx_ready = 1'b0;
    logic [7:0] a_rx_byte = 8'h00;
    logic       a_tx_busy = 1'b0;
    logic       a_tx_req;
    logic [7:0] a_tx_byte;
    logic [4:0] a_level;
    logic       a_full, a_empty, a_overflow;

    // Instance B: line mode, depth 4
    logic       b_rst_n = 1'b0;
    logic       b_rx_ready = 1'b0;
    logic [7:0] b_rx_byte = 8'h00;
    logic       b_tx_busy = 1'b0;
    logic       b_tx_req;
    logic [7:0] b_tx_byte;
    logic [2:0] b_level;
    logic       b_full, b_empty, b_overflow;

    uart_echo_buffered #(
        .DATA_W(8), .DEPTH_LOG2(4), .LINE_MODE(0),
        .EOL(8'h0D), .UPPERCASE(1)
    ) u_a (
        .clk(clk), .reset_n(a_rst_n),
        .rx_ready(a_rx_ready), .rx_byte(a_rx_byte),
        .tx_busy(a_tx_busy), .tx_req(a_tx_req), .tx_byte(a_tx_byte),
        .level(a_level), .full(a_full), .empty(a_empty),
        .overflow(a_overflow)
    );

    uart_echo_buffered #(
        .DATA_W(8), .DEPTH_LOG2(2), .LINE_MODE(1),
        .EOL(8'h0D), .UPPERCASE(0)
    ) u_b (
        .clk(clk), .reset_n(b_rst_n),
        .rx_ready(b_rx_ready), .rx_byte(b_rx_byte),
        .tx_busy(b_tx_busy), .tx_req(b_tx_req), .tx_byte(b_tx_byte),
        .level(b_level), .full(b_full), .empty(b_empty),
        .overflow(b_overflow)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // uart transmitter model: busy for len cycles, rising the cycle after tx_req
    logic a_hold = 1'b0, b_hold = 1'b0;
    int   a_len = 10, b_len = 4;
    int   a_cnt = 0, b_cnt = 0;
    logic a_seen, b_seen;

    always @(posedge clk) begin
        a_seen = a_tx_req;
        b_seen = b_tx_req;
        #1;
        if (a_seen) a_cnt = a_len;
        else if (a_cnt > 0) a_cnt--;
        if (b_seen) b_cnt = b_len;
        else if (b_cnt > 0) b_cnt--;
        a_tx_busy = a_hold || (a_cnt > 0);
        b_tx_busy = b_hold || (b_cnt > 0);
    end

    // Echo capture plus request spacing (requests at least 3 cycles apart)
    logic [7:0] a_q[$];
    logic [7:0] b_q[$];
    int a_gap = 100, b_gap = 100;

    always @(negedge clk) begin
        if (!a_rst_n) a_gap = 100;
        else if (a_tx_req === 1'b1) begin
            if (a_gap < 100) chk("a_req_gap", 32'(a_gap >= 2), 1);
            a_q.push_back(a_tx_byte);
            a_gap = 0;
        end else if (a_gap < 100) a_gap++;
        if (!b_rst_n) b_gap = 100;
        else if (b_tx_req === 1'b1) begin
            if (b_gap < 100) chk("b_req_gap", 32'(b_gap >= 2), 1);
            b_q.push_back(b_tx_byte);
            b_gap = 0;
        end else if (b_gap < 100) b_gap++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_a(input logic [7:0] b);
        a_rx_ready = 1'b1;
        a_rx_byte  = b;
        step();
        a_rx_ready = 1'b0;
    endtask

    task automatic send_b(input logic [7:0] b);
        b_rx_ready = 1'b1;
        b_rx_byte  = b;
        step();
        b_rx_ready = 1'b0;
    endtask

    task automatic wait_q(input bit sel_b, input int n, input int lim);
        for (int i = 0; i < lim; i++) begin
            if ((sel_b ? b_q.size() : a_q.size()) >= n) break;
            step();
        end
    endtask

    function automatic logic [31:0] qa(input int i);
        return (i < a_q.size()) ? 32'(a_q[i]) : 32'hFFFF_FFFF;
    endfunction

    function automatic logic [31:0] qb(input int i);
        return (i < b_q.size()) ? 32'(b_q[i]) : 32'hFFFF_FFFF;
    endfunction

    function automatic logic [7:0] upcase(input logic [7:0] b);
        return (b >= 8'h61 && b <= 8'h7A) ? b - 8'h20 : b;
    endfunction

    logic [7:0] exp_q[$];
    logic [7:0] rb;
    int n;

    initial begin
        // reset state
        repeat (3) step();
        chk("rst_tx_req", 32'(a_tx_req), 0);
        chk("rst_tx_byte", 32'(a_tx_byte), 0);
        chk("rst_level", 32'(a_level), 0);
        chk("rst_empty", 32'(a_empty), 1);
        chk("rst_full", 32'(a_full), 0);
        chk("rst_ovf", 32'(a_overflow), 0);
        chk("rst_b_empty", 32'(b_empty), 1);
        a_rst_n = 1'b1;
        b_rst_n = 1'b1;
        repeat (2) step();

        // single byte latency, 10-cycle busy
        a_len = 10;
        send_a(8'h41);
        chk("t1_level_c1", 32'(a_level), 1);
        chk("t1_req_c1", 32'(a_tx_req), 0);
        step();
        chk("t1_req_c2", 32'(a_tx_req), 1);
        chk("t1_byte_c2", 32'(a_tx_byte), 32'h41);
        step();
        chk("t1_level_c3", 32'(a_level), 0);
        chk("t1_req_c3", 32'(a_tx_req), 0);
        chk("t1_ovf", 32'(a_overflow), 0);
        repeat (15) step();
        chk("t1_count", 32'(a_q.size()), 1);

        // burst of 20 while busy: 16 stored + 1 already popped
        a_q.delete();
        a_len  = 3;
        a_hold = 1'b1;
        for (int i = 0; i < 20; i++) send_a(8'(i));
        chk("burst_level", 32'(a_level), 16);
        chk("burst_full", 32'(a_full), 1);
        chk("burst_ovf", 32'(a_overflow), 1);
        a_hold = 1'b0;
        wait_q(0, 17, 400);
        repeat (10) step();
        chk("burst_count", 32'(a_q.size()), 17);
        for (int i = 0; i < 17; i++) chk("burst_seq", qa(i), 32'(i));
        chk("burst_empty", 32'(a_empty), 1);
        chk("burst_ovf_sticky", 32'(a_overflow), 1);

        // reset while in HOLD with level 3
        a_q.delete();
        a_hold = 1'b1;
        send_a(8'h70); send_a(8'h71); send_a(8'h72); send_a(8'h73);
        repeat (2) step();
        chk("rh_level", 32'(a_level), 3);
        chk("rh_count", 32'(a_q.size()), 1);
        a_rst_n = 1'b0;
        #2;
        chk("rh_tx_req", 32'(a_tx_req), 0);
        chk("rh_tx_byte", 32'(a_tx_byte), 0);
        chk("rh_level0", 32'(a_level), 0);
        chk("rh_empty", 32'(a_empty), 1);
        chk("rh_full", 32'(a_full), 0);
        chk("rh_ovf", 32'(a_overflow), 0);
        step();
        a_rst_n = 1'b1;
        repeat (5) step();
        a_hold = 1'b0;
        repeat (20) step();
        chk("rh_no_req", 32'(a_q.size()), 1);
        send_a(8'h62);
        wait_q(0, 2, 50);
        chk("rh_new", qa(1), 32'h42);

        // upper-casing
        a_q.delete();
        send_a(8'h61); send_a(8'h7A); send_a(8'h7B); send_a(8'h41);
        wait_q(0, 4, 100);
        chk("uc_0", qa(0), 32'h41);
        chk("uc_1", qa(1), 32'h5A);
        chk("uc_2", qa(2), 32'h7B);
        chk("uc_3", qa(3), 32'h41);

        // random bytes, random gaps and busy length
        a_q.delete();
        exp_q.delete();
        a_len = $urandom_range(1, 6);
        for (int i = 0; i < 12; i++) begin
            rb = 8'($urandom_range(0, 255));
            exp_q.push_back(upcase(rb));
            send_a(rb);
            repeat ($urandom_range(0, 3)) step();
        end
        wait_q(0, 12, 500);
        chk("rnd_count", 32'(a_q.size()), 12);
        for (int i = 0; i < 12; i++) chk("rnd_seq", qa(i), 32'(exp_q[i]));
        chk("rnd_ovf", 32'(a_overflow), 0);

        // line mode: hold until EOL
        b_len = 4;
        send_b(8'h68); send_b(8'h69);
        repeat (10) step();
        chk("ln_held", 32'(b_q.size()), 0);
        chk("ln_level", 32'(b_level), 2);
        send_b(8'h0D);
        step();
        chk("ln_req_c2", 32'(b_tx_req), 1);
        chk("ln_byte_c2", 32'(b_tx_byte), 32'h68);
        wait_q(1, 3, 100);
        repeat (8) step();
        chk("ln_0", qb(0), 32'h68);
        chk("ln_1", qb(1), 32'h69);
        chk("ln_2", qb(2), 32'h0D);
        chk("ln_level0", 32'(b_level), 0);
        // no lines left pending: next byte is held
        send_b(8'h78);
        repeat (12) step();
        chk("ln_rehold", 32'(b_q.size()), 3);
        chk("ln_rehold_lvl", 32'(b_level), 1);

        // random short line
        b_rst_n = 1'b0;
        step();
        b_rst_n = 1'b1;
        step();
        b_q.delete();
        exp_q.delete();
        b_len = $urandom_range(1, 5);
        n = $urandom_range(1, 3);
        for (int i = 0; i < n; i++) begin
            do rb = 8'($urandom_range(0, 255)); while (rb == 8'h0D);
            exp_q.push_back(rb);
            send_b(rb);
        end
        repeat (8) step();
        chk("lr_held", 32'(b_q.size()), 0);
        exp_q.push_back(8'h0D);
        send_b(8'h0D);
        wait_q(1, n + 1, 100);
        for (int i = 0; i <= n; i++) chk("lr_seq", qb(i), 32'(exp_q[i]));

        // over-long line: force drain
        b_rst_n = 1'b0;
        step();
        b_rst_n = 1'b1;
        step();
        b_q.delete();
        b_len = 2;
        for (int i = 0; i < 6; i++) begin
            send_b(8'h30 + 8'(i));
            if (i == 3) begin
                chk("fd_full", 32'(b_full), 1);
                chk("fd_level", 32'(b_level), 4);
            end
        end
        chk("fd_ovf", 32'(b_overflow), 1);
        wait_q(1, 5, 200);
        repeat (10) step();
        chk("fd_count", 32'(b_q.size()), 5);
        chk("fd_0", qb(0), 32'h30);
        chk("fd_1", qb(1), 32'h31);
        chk("fd_2", qb(2), 32'h32);
        chk("fd_3", qb(3), 32'h33);
        chk("fd_4", qb(4), 32'h35);
        chk("fd_empty", 32'(b_empty), 1);
        send_b(8'h79);
        repeat (12) step();
        chk("fd_rehold", 32'(b_q.size()), 5);
        chk("fd_rehold_lvl", 32'(b_level), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
